// File: rtl/serial_shift_unit.sv
// Multi-cycle shifter for the R-type shift instructions (sll/srl/sra and the variable forms).
// Shifts one bit per clock under a start/busy/done handshake; result holds until the next accept.
module serial_shift_unit #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] amount,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  state_t           state;
  state_t           state_nxt;
  logic [AMT_W-1:0] cnt;
  logic [1:0]       op_q;
  logic             accept;
  logic             no_shift;
  logic             unused_amount;

  // Only the low AMT_W bits of the amount operand select the shift distance.
  assign unused_amount = ^amount[WIDTH-1:AMT_W];

  assign accept   = start && (state != SHIFT);
  assign no_shift = (amount[AMT_W-1:0] == '0) || (op == OP_RSV);
  assign busy     = (state == SHIFT);
  assign done     = (state == DONE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          state_nxt = no_shift ? DONE : SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      SHIFT: begin
        if (cnt == AMT_W'(1)) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      op_q   <= '0;
      cnt    <= '0;
    end else if (accept) begin
      result <= data_in;
      op_q   <= op;
      cnt    <= amount[AMT_W-1:0];
    end else if (state == SHIFT) begin
      cnt <= cnt - 1'b1;
      case (op_q)
        OP_SLL:  result <= {result[WIDTH-2:0], 1'b0};
        OP_SRL:  result <= {1'b0, result[WIDTH-1:1]};
        OP_SRA:  result <= {result[WIDTH-1], result[WIDTH-1:1]};
        default: result <= result;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_shift_unit.sv
// Randomized and directed stimulus for serial_shift_unit; a queue-based scoreboard
// compares each done pulse against a plain-arithmetic shift model.
module tb_serial_shift_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] data_in;
  logic [31:0] amount;
  logic        busy;
  logic        done;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    int          cyc;
    int          busy_cycles;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   tests    = 0;
  int   failures = 0;
  int   busy_cnt = 0;

  serial_shift_unit #(.WIDTH(32), .AMT_W(5)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .data_in(data_in),
    .amount (amount),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] d,
                                        input logic [31:0] a);
    int sh;
    sh = int'(a % 32);
    case (o)
      2'd0:    return d << sh;
      2'd1:    return d >> sh;
      2'd2:    return $unsigned($signed(d) >>> sh);
      default: return d;
    endcase
  endfunction

  // Monitor: pops the scoreboard on every done pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_cnt = 0;
      end else begin
        if (busy) busy_cnt++;
        if (done) begin
          if (sb.size() == 0) begin
            tests++;
            failures++;
            $display("FAIL spurious_done: got done with result 0x%08h, expected no done (t=%0t)",
                     result, $time);
          end else begin
            e = sb.pop_front();
            check("result", result, e.res);
            check("done_cycle", cyc, e.cyc);
            check("busy_cycles", busy_cnt, e.busy_cycles);
          end
          busy_cnt = 0;
        end
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] d, input logic [31:0] a);
    int   guard;
    int   eff;
    exp_t e;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      check("issue_timeout", 32'(guard), 32'd0);
    end
    start   = 1'b1;
    op      = o;
    data_in = d;
    amount  = a;
    @(posedge clk);
    #1;
    start = 1'b0;
    eff = (o == 2'd3) ? 0 : int'(a % 32);
    e.res         = model(o, d, a);
    e.cyc         = cyc + eff;
    e.busy_cycles = eff;
    sb.push_back(e);
  endtask

  initial begin
    int guard;
    rst_n   = 1'b0;
    start   = 1'b0;
    op      = 2'd0;
    data_in = '0;
    amount  = '0;
    #12;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    #3;
    rst_n = 1'b1;

    // Directed cases.
    issue(2'd0, 32'h0000_0001, 32'd4);
    issue(2'd2, 32'h8000_0000, 32'd31);
    issue(2'd1, 32'h8000_0000, 32'd31);
    issue(2'd1, 32'h0000_00F0, 32'h0000_0025);
    issue(2'd0, 32'hDEAD_BEEF, 32'd0);
    issue(2'd3, 32'hDEAD_BEEF, 32'd17);
    issue(2'd2, 32'hDEAD_BEEF, 32'hFFFF_FFE0);

    // A start pulse during SHIFT must be ignored.
    issue(2'd1, 32'hA5A5_0F0F, 32'd10);
    @(negedge clk);
    @(negedge clk);
    start   = 1'b1;
    op      = 2'd0;
    data_in = 32'h1234_5678;
    amount  = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    // Back-to-back: the next issue is accepted in the DONE cycle.
    issue(2'd0, 32'h0000_0003, 32'd3);
    issue(2'd2, 32'hF000_0000, 32'd2);

    // Randomized traffic with occasional idle gaps.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 4) == 0) a = a & 32'hFFFF_FFE0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(2'($urandom_range(0, 3)), $urandom, a);
    end

    // Asynchronous reset in the middle of a 10-bit shift.
    issue(2'd0, 32'h1234_5678, 32'd10);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_result", result, 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("post_reset_idle", {30'd0, busy, done}, 32'd0);
    issue(2'd0, 32'h0000_0003, 32'd2);

    guard = 0;
    while (sb.size() > 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("drain_pending", 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
